i2s_codec_link: RTL and testbench

- Bidirectional I2S link between the external audio codec and the EQ engine.
- Generates the MCLK, SCLK and LRCLK codec clocks and deserializes 16-bit left/right ADC samples.
- Presents each sample pair with valid / valid_rise / valid_fall framing to the EQ engine.
- Serializes the equalized left/right result back to the codec DAC, one frame later.

---
 rtl/i2s_codec_pkg.sv | 23 ++
 rtl/i2s_timing_gen.sv | 51 +++++
 rtl/i2s_codec_link.sv | 114 +++++++++++
 tb/tb_i2s_codec_link.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/i2s_codec_pkg.sv
// Shared constants and types for the I2S codec link: timebase bit positions,
// strobe phases within a bit period, and the sample-presentation window.
package i2s_codec_pkg;

  localparam int CNT_W    = 10;
  localparam int MCLK_BIT = 1;
  localparam int SCLK_BIT = 3;
  localparam int LR_BIT   = 9;

  localparam logic [3:0] RX_PHASE = 4'd7;
  localparam logic [3:0] TX_PHASE = 4'd15;

  localparam logic [CNT_W-1:0] VALID_START = 10'd776;
  localparam logic [CNT_W-1:0] VALID_END   = 10'd1023;

  typedef logic signed [15:0] smpl_t;

  // I2S carries the 16 data bits in slots 1..16 of each channel half-frame.
  function automatic logic in_data_slot(input logic [4:0] s);
    return (s >= 5'd1) && (s <= 5'd16);
  endfunction

endpackage

// File: rtl/i2s_timing_gen.sv
// Free-running frame timebase: codec clocks, codec reset release, startup
// frame counting and the per-bit strobes used by the rx/tx datapath.
module i2s_timing_gen
  import i2s_codec_pkg::*;
#(
  parameter int STARTUP_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             MCLK,
  output logic             SCLK,
  output logic             LRCLK,
  output logic             codec_rst_n,
  output logic             startup_done,
  output logic             rx_strobe,
  output logic             tx_strobe,
  output logic [4:0]       slot,
  output logic             chan,
  output logic             frame_wrap
);

  logic [7:0] startup_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      codec_rst_n <= 1'b0;
      startup_cnt <= '0;
    end else begin
      cnt <= cnt + 10'd1;
      if (frame_wrap) begin
        codec_rst_n <= 1'b1;
        // The release wrap itself is not a startup frame; count later wraps only.
        if (codec_rst_n && !startup_done)
          startup_cnt <= startup_cnt + 8'd1;
      end
    end
  end

  assign startup_done = (startup_cnt == 8'(STARTUP_FRAMES));
  assign MCLK         = cnt[MCLK_BIT];
  assign SCLK         = cnt[SCLK_BIT];
  assign LRCLK        = cnt[LR_BIT];
  assign slot         = cnt[8:4];
  assign chan         = cnt[LR_BIT];
  assign rx_strobe    = (cnt[3:0] == RX_PHASE);
  assign tx_strobe    = (cnt[3:0] == TX_PHASE);
  assign frame_wrap   = (cnt == VALID_END);

endmodule

// File: rtl/i2s_codec_link.sv
// I2S link to the audio codec: deserializes ADC samples for the EQ engine with
// valid framing and serializes the EQ result back to the DAC one frame later.
module i2s_codec_link
  import i2s_codec_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int STARTUP_FRAMES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sdout,
  input  logic signed [DATA_W-1:0] lft_eq,
  input  logic signed [DATA_W-1:0] rht_eq,
  output logic                     MCLK,
  output logic                     SCLK,
  output logic                     LRCLK,
  output logic                     sdin,
  output logic                     codec_rst_n,
  output logic signed [DATA_W-1:0] lft_in,
  output logic signed [DATA_W-1:0] rht_in,
  output logic                     valid,
  output logic                     valid_rise,
  output logic                     valid_fall
);

  logic [CNT_W-1:0] cnt;
  logic             startup_done;
  logic             rx_strobe;
  logic             tx_strobe;
  logic [4:0]       slot;
  logic             chan;
  logic             frame_wrap;

  smpl_t      lft_sr, rht_sr;
  smpl_t      tx_l, tx_r;
  logic [4:0] nslot;
  logic [3:0] bidx;
  logic       tx_bit;
  logic       present;

  i2s_timing_gen #(
    .STARTUP_FRAMES(STARTUP_FRAMES)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .cnt         (cnt),
    .MCLK        (MCLK),
    .SCLK        (SCLK),
    .LRCLK       (LRCLK),
    .codec_rst_n (codec_rst_n),
    .startup_done(startup_done),
    .rx_strobe   (rx_strobe),
    .tx_strobe   (tx_strobe),
    .slot        (slot),
    .chan        (chan),
    .frame_wrap  (frame_wrap)
  );

  // Output registers load on the cycle the last right bit arrives, so the
  // final bit is folded in directly and the pair is stable from VALID_START.
  assign present = (cnt == VALID_START - 10'd1);

  // sdin for the upcoming slot; 16 - nslot in four bits is ~(nslot - 1).
  always_comb begin
    nslot  = slot + 5'd1;
    bidx   = ~(nslot[3:0] - 4'd1);
    tx_bit = 1'b0;
    if (in_data_slot(nslot))
      tx_bit = chan ? tx_r[bidx] : tx_l[bidx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lft_sr     <= '0;
      rht_sr     <= '0;
      lft_in     <= '0;
      rht_in     <= '0;
      tx_l       <= '0;
      tx_r       <= '0;
      sdin       <= 1'b0;
      valid      <= 1'b0;
      valid_rise <= 1'b0;
      valid_fall <= 1'b0;
    end else begin
      if (rx_strobe && in_data_slot(slot)) begin
        if (chan) rht_sr <= {rht_sr[14:0], sdout};
        else      lft_sr <= {lft_sr[14:0], sdout};
      end

      valid_rise <= 1'b0;
      if (present) begin
        lft_in     <= lft_sr;
        rht_in     <= {rht_sr[14:0], sdout};
        valid      <= startup_done;
        valid_rise <= startup_done;
      end

      valid_fall <= 1'b0;
      if (frame_wrap) begin
        valid      <= 1'b0;
        valid_fall <= valid;
      end

      if (valid_fall) begin
        tx_l <= lft_eq;
        tx_r <= rht_eq;
      end

      if (tx_strobe)
        sdin <= tx_bit;
    end
  end

endmodule

// File: tb/tb_i2s_codec_link.sv
// Bench for i2s_codec_link: a codec model drives I2S frames and random EQ words,
// and every cycle's outputs are compared against a frame/phase reference model.
module tb_i2s_codec_link;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sdout = 1'b0;
  logic signed [15:0] lft_eq = '0;
  logic signed [15:0] rht_eq = '0;
  logic               MCLK, SCLK, LRCLK, sdin, codec_rst_n;
  logic signed [15:0] lft_in, rht_in;
  logic               valid, valid_rise, valid_fall;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since reset release and per-frame words.
  int          t;
  int          run;
  logic [15:0] cur_l, cur_r, prev_l, prev_r, tx_l, tx_r;

  always #5 clk = ~clk;

  i2s_codec_link #(.DATA_W(16), .STARTUP_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sdout      (sdout),
    .lft_eq     (lft_eq),
    .rht_eq     (rht_eq),
    .MCLK       (MCLK),
    .SCLK       (SCLK),
    .LRCLK      (LRCLK),
    .sdin       (sdin),
    .codec_rst_n(codec_rst_n),
    .lft_in     (lft_in),
    .rht_in     (rht_in),
    .valid      (valid),
    .valid_rise (valid_rise),
    .valid_fall (valid_fall)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  function automatic logic [39:0] dut_vec();
    return {MCLK, SCLK, LRCLK, sdin, codec_rst_n, valid, valid_rise, valid_fall,
            lft_in, rht_in};
  endfunction

  task automatic model_reset();
    cur_l = '0; cur_r = '0; prev_l = '0; prev_r = '0; tx_l = '0; tx_r = '0;
    t = 0;
  endtask

  // One cycle, called at the negedge: refresh model, compare, drive inputs.
  task automatic step();
    int p, f, sd;
    bit ch, in_slot;
    logic [15:0] exp_l, exp_r, tx_w, rx_w;
    logic e_sdin, e_valid, e_rise, e_fall;
    p = t % 1024;
    f = t / 1024;
    sd = (p / 16) % 32;
    ch = (p >= 512);
    in_slot = (sd >= 1) && (sd <= 16);

    if (p == 0) begin
      prev_l = cur_l; prev_r = cur_r;
      if (run == 0 && f == 3) begin
        cur_l = 16'hA5C3; cur_r = 16'h8001;
      end else begin
        cur_l = 16'($urandom); cur_r = 16'($urandom);
      end
      if (run == 0 && f == 5) begin
        lft_eq = 16'sh7FFF; rht_eq = 16'sh1234;
      end else begin
        lft_eq = 16'($urandom); rht_eq = 16'($urandom);
      end
      tx_l = lft_eq; tx_r = rht_eq;
    end

    exp_l   = (p >= 776) ? cur_l : prev_l;
    exp_r   = (p >= 776) ? cur_r : prev_r;
    e_valid = (f >= 3) && (p >= 776);
    e_rise  = (f >= 3) && (p == 776);
    e_fall  = (f >= 4) && (p == 0);
    tx_w    = ch ? tx_r : tx_l;
    e_sdin  = (f >= 4) && in_slot && tx_w[16 - sd];

    chk("outputs", {24'h0, dut_vec()},
        {24'h0, (t % 4) >= 2, (t % 16) >= 8, ch, e_sdin, f >= 1,
         e_valid, e_rise, e_fall, exp_l, exp_r});

    if (run == 0) begin
      if (t == 1023)          chk("codec_rst_n_before_wrap", {63'h0, codec_rst_n}, 64'd0);
      if (t == 1024)          chk("codec_rst_n_after_wrap", {63'h0, codec_rst_n}, 64'd1);
      if (t == 2 * 1024 + 776) chk("startup_valid_suppressed", {63'h0, valid}, 64'd0);
      if (t == 3 * 1024 + 775) chk("valid_before_window", {63'h0, valid}, 64'd0);
      if (t == 3 * 1024 + 776) begin
        chk("lft_in_a5c3", {48'h0, $unsigned(lft_in)}, 64'h0000_0000_0000_A5C3);
        chk("rht_in_8001", {48'h0, $unsigned(rht_in)}, 64'h0000_0000_0000_8001);
        chk("valid_rise_first", {63'h0, valid_rise}, 64'd1);
      end
      if (t == 3 * 1024 + 777) chk("valid_rise_single", {63'h0, valid_rise}, 64'd0);
      if (t == 4 * 1024)       chk("valid_fall_pulse", {63'h0, valid_fall}, 64'd1);
      if (t == 5 * 1024 + 1 * 16 + 8)       chk("sdin_7fff_msb", {63'h0, sdin}, 64'd0);
      if (t == 5 * 1024 + 2 * 16 + 8)       chk("sdin_7fff_b14", {63'h0, sdin}, 64'd1);
      if (t == 5 * 1024 + 512 + 3 * 16 + 8) chk("sdin_1234_b13", {63'h0, sdin}, 64'd0);
      if (t == 5 * 1024 + 512 + 4 * 16 + 8) chk("sdin_1234_b12", {63'h0, sdin}, 64'd1);
    end else begin
      if (t == 0) chk("mid_reset_state", {24'h0, dut_vec()}, 64'h0);
      if (t == 3 * 1024 + 775) chk("restart_no_early_valid", {63'h0, valid}, 64'd0);
      if (t == 3 * 1024 + 776) chk("restart_valid_rise", {63'h0, valid_rise}, 64'd1);
    end

    rx_w  = ch ? cur_r : cur_l;
    sdout = in_slot ? rx_w[16 - sd] : 1'($urandom);
    if (p == 5 || p == 500 || (p != 0 && $urandom_range(63) == 0)) begin
      lft_eq = 16'($urandom); rht_eq = 16'($urandom);
    end
    t++;
  endtask

  initial begin
    run = 0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("reset_state", {24'h0, dut_vec()}, 64'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    while (t <= 7 * 1024 + 600) begin
      step();
      if (t <= 7 * 1024 + 600) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run = 1;
    model_reset();
    while (t < 6 * 1024) begin
      step();
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
